// File: rtl/ycbcr_stream_ctrl_if.sv
// rtl/ycbcr_stream_ctrl_if.sv - pixel-in, converter and binary-stream signal bundle of ycbcr_stream_ctrl
// master drives pixels and returned luma; slave is the controller.
interface ycbcr_stream_ctrl_if;
    logic        i_vsync;
    logic        i_hsync;
    logic        i_de;
    logic [23:0] i_rgb;
    logic [7:0]  o_r_8b;
    logic [7:0]  o_g_8b;
    logic [7:0]  o_b_8b;
    logic [7:0]  i_y_8b;
    logic        o_vsync;
    logic        o_hsync;
    logic        o_de;
    logic [7:0]  o_y;
    logic [7:0]  o_bin;
    logic [7:0]  o_thresh;
    logic [15:0] o_frame_cnt;
    logic        o_line_err;

    modport master (
        output i_vsync, i_hsync, i_de, i_rgb, i_y_8b,
        input  o_r_8b, o_g_8b, o_b_8b, o_vsync, o_hsync, o_de, o_y, o_bin,
               o_thresh, o_frame_cnt, o_line_err
    );

    modport slave (
        input  i_vsync, i_hsync, i_de, i_rgb, i_y_8b,
        output o_r_8b, o_g_8b, o_b_8b, o_vsync, o_hsync, o_de, o_y, o_bin,
               o_thresh, o_frame_cnt, o_line_err
    );
endinterface

// File: rtl/ycbcr_stream_ctrl.sv
// rtl/ycbcr_stream_ctrl.sv - sequences the RGB-to-luma converter and binarizes its luma into a pixel stream
// Optional adaptive per-frame threshold: define YC_ADAPTIVE_THRESH_EN.
module ycbcr_stream_ctrl #(
    parameter int unsigned LAT         = 4,
    parameter logic [7:0]  THRESH_INIT = 8'd100
) (
    input logic                clk,
    input logic                rst_n,
    ycbcr_stream_ctrl_if.slave sif
);
    localparam int unsigned DEPTH = LAT + 1;

    localparam logic [1:0] S_WAIT   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;

    logic [23:0]      rgb_q;
    logic [DEPTH-1:0] vs_sr_q, vs_sr_d;
    logic [DEPTH-1:0] hs_sr_q, hs_sr_d;
    logic [DEPTH-1:0] de_sr_q, de_sr_d;
    logic             vs_out_q, hs_out_q, de_out_q, de_out_d, de_prev_q;
    logic [7:0]       y_q, bin_q, bin_d;
    logic [7:0]       thresh_q, thresh_d;
    logic [1:0]       state_q, state_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [11:0]      line_cnt_q, line_cnt_d;
    logic [11:0]      line_ref_q, line_ref_d;
    logic             ref_valid_q, ref_valid_d;
    logic             line_err_q, line_err_d;

    logic q_vs, q_hs, q_de;
    logic vs_rise, de_fall, running;

    // Tap LAT+1 lines up with the luma returning from the converter.
    assign q_vs = vs_sr_q[DEPTH-1];
    assign q_hs = hs_sr_q[DEPTH-1];
    assign q_de = de_sr_q[DEPTH-1];

    // vs_out_q is q_vs one clock later, so it doubles as the edge-detect history.
    assign vs_rise = q_vs & ~vs_out_q;
    assign de_fall = ~q_de & de_prev_q;
    assign running = (state_q != S_WAIT);

    assign vs_sr_d = (vs_sr_q << 1) | DEPTH'(sif.i_vsync);
    assign hs_sr_d = (hs_sr_q << 1) | DEPTH'(sif.i_hsync);
    assign de_sr_d = (de_sr_q << 1) | DEPTH'(sif.i_de);

`ifdef YC_ADAPTIVE_THRESH_EN
    logic [7:0] ymin_q, ymin_d;
    logic [7:0] ymax_q, ymax_d;
    logic [8:0] thr_sum;

    assign thr_sum = {1'b0, ymin_q} + {1'b0, ymax_q} + 9'd1;

    always_comb begin
        ymin_d   = ymin_q;
        ymax_d   = ymax_q;
        thresh_d = thresh_q;
        if (state_q == S_RUN && q_de) begin
            if (sif.i_y_8b < ymin_q) ymin_d = sif.i_y_8b;
            if (sif.i_y_8b > ymax_q) ymax_d = sif.i_y_8b;
        end else if (state_q == S_UPDATE) begin
            // An empty frame leaves ymax below ymin; keep the old threshold then.
            if (ymax_q >= ymin_q) thresh_d = 8'(thr_sum >> 1);
            // A pixel arriving during UPDATE opens the next frame's statistics.
            ymin_d = q_de ? sif.i_y_8b : 8'hFF;
            ymax_d = q_de ? sif.i_y_8b : 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ymin_q <= 8'hFF;
            ymax_q <= 8'h00;
        end else begin
            ymin_q <= ymin_d;
            ymax_q <= ymax_d;
        end
    end
`else
    assign thresh_d = thresh_q;
`endif

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            S_WAIT:   if (vs_rise) state_d = S_RUN;
            S_RUN:    if (vs_rise) state_d = S_UPDATE;
            S_UPDATE: begin
                state_d     = S_RUN;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
            default:  state_d = S_WAIT;
        endcase
    end

    always_comb begin
        line_cnt_d  = line_cnt_q;
        line_ref_d  = line_ref_q;
        ref_valid_d = ref_valid_q;
        line_err_d  = line_err_q;
        if (q_de) begin
            line_cnt_d = line_cnt_q + 12'd1;
        end else if (de_fall) begin
            line_cnt_d = 12'd0;
            if (!ref_valid_q) begin
                line_ref_d  = line_cnt_q;
                ref_valid_d = 1'b1;
            end else if (line_cnt_q != line_ref_q) begin
                line_err_d = 1'b1;
            end
        end
    end

    // The partial frame seen before the first vsync is blanked.
    assign de_out_d = q_de & running;
    assign bin_d    = (running && (sif.i_y_8b > thresh_q)) ? 8'hFF : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q       <= 24'd0;
            vs_sr_q     <= '0;
            hs_sr_q     <= '0;
            de_sr_q     <= '0;
            vs_out_q    <= 1'b0;
            hs_out_q    <= 1'b0;
            de_out_q    <= 1'b0;
            de_prev_q   <= 1'b0;
            y_q         <= 8'd0;
            bin_q       <= 8'd0;
            thresh_q    <= THRESH_INIT;
            state_q     <= S_WAIT;
            frame_cnt_q <= 16'd0;
            line_cnt_q  <= 12'd0;
            line_ref_q  <= 12'd0;
            ref_valid_q <= 1'b0;
            line_err_q  <= 1'b0;
        end else begin
            rgb_q       <= sif.i_rgb;
            vs_sr_q     <= vs_sr_d;
            hs_sr_q     <= hs_sr_d;
            de_sr_q     <= de_sr_d;
            vs_out_q    <= q_vs;
            hs_out_q    <= q_hs;
            de_out_q    <= de_out_d;
            de_prev_q   <= q_de;
            y_q         <= sif.i_y_8b;
            bin_q       <= bin_d;
            thresh_q    <= thresh_d;
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            line_cnt_q  <= line_cnt_d;
            line_ref_q  <= line_ref_d;
            ref_valid_q <= ref_valid_d;
            line_err_q  <= line_err_d;
        end
    end

    assign sif.o_r_8b      = rgb_q[23:16];
    assign sif.o_g_8b      = rgb_q[15:8];
    assign sif.o_b_8b      = rgb_q[7:0];
    assign sif.o_vsync     = vs_out_q;
    assign sif.o_hsync     = hs_out_q;
    assign sif.o_de        = de_out_q;
    assign sif.o_y         = y_q;
    assign sif.o_bin       = bin_q;
    assign sif.o_thresh    = thresh_q;
    assign sif.o_frame_cnt = frame_cnt_q;
    assign sif.o_line_err  = line_err_q;
endmodule

// File: tb/tb_ycbcr_stream_ctrl.sv
// tb/tb_ycbcr_stream_ctrl.sv - self-checking bench for ycbcr_stream_ctrl against a frame-level reference model
module tb_ycbcr_stream_ctrl;
    localparam int LAT   = 4;
    localparam int OL    = LAT + 2;
    localparam int HN    = 8192;
    localparam int NEVER = 1 << 30;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ycbcr_stream_ctrl_if vif ();

    ycbcr_stream_ctrl #(.LAT(LAT), .THRESH_INIT(8'd100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (vif)
    );

    int checks = 0;
    int errors = 0;

    logic        h_vs [HN];
    logic        h_hs [HN];
    logic        h_de [HN];
    logic [23:0] h_rgb[HN];
    logic [7:0]  h_y  [HN];
    logic        h_de_exp [HN];
    logic [7:0]  h_bin_exp[HN];

    int n;
    bit armed;
    int ymin, ymax;
    int thr_prev, thr_pend, thr_cyc;
    int cnt_prev, cnt_pend, cnt_cyc;
    int line_run, line_ref, err_cyc;
    bit ref_valid;

    // Stand-in converter: weighted luma of the pixel.
    function automatic logic [7:0] luma(input logic [23:0] rgb);
        int s;
        s = int'(rgb[23:16]) + 2 * int'(rgb[15:8]) + int'(rgb[7:0]);
        return 8'(s >> 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < HN; i++) begin
            h_vs[i] = 1'b0; h_hs[i] = 1'b0; h_de[i] = 1'b0;
            h_rgb[i] = 24'd0; h_y[i] = 8'd0;
            h_de_exp[i] = 1'b0; h_bin_exp[i] = 8'd0;
        end
        n = 8; armed = 1'b0; ymin = 256; ymax = -1;
        thr_prev = 100; thr_pend = 100; thr_cyc = 0;
        cnt_prev = 0; cnt_pend = 0; cnt_cyc = 0;
        line_run = 0; line_ref = 0; ref_valid = 1'b0; err_cyc = NEVER;
    endtask

    // Input index k reaches the outputs OL clocks later; a vsync rise at j
    // shows its frame result from cycle j+OL+1 and thresholds pixels from j+2.
    task automatic record(input logic vs, input logic hs, input logic de, input logic [23:0] rgb);
        bit rise, en;
        int thr_k, y;
        h_vs[n] = vs; h_hs[n] = hs; h_de[n] = de; h_rgb[n] = rgb; h_y[n] = luma(rgb);
        y     = int'(h_y[n]);
        rise  = vs && !h_vs[n-1];
        en    = armed;
        thr_k = (n + LAT + 1 >= thr_cyc) ? thr_pend : thr_prev;
        h_de_exp[n]  = de && en;
        h_bin_exp[n] = (en && y > thr_k) ? 8'hFF : 8'h00;
        if (en && de) begin
            if (y < ymin) ymin = y;
            if (y > ymax) ymax = y;
        end
        if (rise) begin
            if (armed) begin
                cnt_prev = cnt_pend; cnt_pend = (cnt_pend + 1) % 65536; cnt_cyc = n + OL + 1;
`ifdef YC_ADAPTIVE_THRESH_EN
                if (ymax >= ymin) begin
                    thr_prev = thr_pend; thr_pend = (ymin + ymax + 1) / 2; thr_cyc = n + OL + 1;
                end
`endif
                ymin = 256; ymax = -1;
            end else begin
                armed = 1'b1;
            end
        end
        if (de) begin
            line_run++;
        end else if (h_de[n-1]) begin
            if (!ref_valid) begin
                line_ref = line_run; ref_valid = 1'b1;
            end else if (line_run != line_ref && err_cyc == NEVER) begin
                err_cyc = n + OL;
            end
            line_run = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic vs, input logic hs, input logic de, input logic [23:0] rgb);
        logic [67:0] obs, expv;
        int k;
        @(posedge clk); #1;
        if (n >= HN - 1) begin
            $display("FAIL history_overflow observed=%0d limit=%0d", n, HN - 1);
            $fatal(1);
        end
        vif.i_vsync = vs; vif.i_hsync = hs; vif.i_de = de; vif.i_rgb = rgb;
        record(vs, hs, de, rgb);
        vif.i_y_8b = h_y[n-(LAT+1)];
        @(negedge clk);
        k = n - OL;
        obs  = {vif.o_vsync, vif.o_hsync, vif.o_de, vif.o_y, vif.o_bin, vif.o_thresh,
                vif.o_frame_cnt, vif.o_line_err, vif.o_r_8b, vif.o_g_8b, vif.o_b_8b};
        expv = {h_vs[k], h_hs[k], h_de_exp[k], h_y[k], h_bin_exp[k],
                (n >= thr_cyc) ? 8'(thr_pend) : 8'(thr_prev),
                (n >= cnt_cyc) ? 16'(cnt_pend) : 16'(cnt_prev),
                (n >= err_cyc), h_rgb[n-1]};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL stream cycle=%0d observed=%h expected=%h", n, obs, expv);
        end
        n++;
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) step(1'b0, 1'b0, 1'b0, 24'd0);
    endtask

    task automatic vsync_pulse();
        step(1'b1, 1'b0, 1'b0, 24'd0);
        step(1'b1, 1'b0, 1'b0, 24'd0);
        idle(3);
    endtask

    task automatic pix(input logic [7:0] y);
        step(1'b0, 1'b0, 1'b1, {y, y, y});
    endtask

    task automatic pix_probe(input string tag, input logic [7:0] y, input logic [7:0] expbin);
        pix(y);
        idle(OL - 1);
        chk({tag, "_early"}, 32'(vif.o_de), 32'd0);
        idle(1);
        chk(tag, {22'd0, vif.o_de, vif.o_bin}, {23'd1, expbin});
    endtask

    task automatic line(input int w, input bit rnd);
        step(1'b0, 1'b1, 1'b0, 24'd0);
        step(1'b0, 1'b1, 1'b0, 24'd0);
        idle(2);
        for (int i = 0; i < w; i++) step(1'b0, 1'b0, 1'b1, rnd ? 24'($urandom) : {3{8'd50}});
        idle(3);
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        vif.i_vsync = 1'b0; vif.i_hsync = 1'b0; vif.i_de = 1'b0;
        vif.i_rgb = 24'd0; vif.i_y_8b = 8'd0;
        #1;
        chk("reset_flags_data", {12'd0, vif.o_vsync, vif.o_hsync, vif.o_de, vif.o_line_err,
                                 vif.o_y, vif.o_bin}, 32'd0);
        chk("reset_frame_cnt", 32'(vif.o_frame_cnt), 32'd0);
        chk("reset_rgb", {8'd0, vif.o_r_8b, vif.o_g_8b, vif.o_b_8b}, 32'd0);
        chk("reset_thresh", 32'(vif.o_thresh), 32'd100);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int w, l;
        apply_reset();

        // Partial frame after reset stays blanked.
        for (int i = 0; i < 10; i++) pix(8'd200);
        chk("prevsync_de", 32'(vif.o_de), 32'd0);
        chk("prevsync_bin", 32'(vif.o_bin), 32'd0);
        idle(4);
        vsync_pulse();
        idle(4);

        pix_probe("bin_101", 8'd101, 8'hFF);
        pix_probe("bin_100", 8'd100, 8'h00);

        pix(8'd20); idle(2); pix(8'd200); idle(3);
        vsync_pulse();
        idle(10);
`ifdef YC_ADAPTIVE_THRESH_EN
        chk("thresh_after_frame", 32'(vif.o_thresh), 32'd110);
        pix_probe("bin_110", 8'd110, 8'h00);
`else
        chk("thresh_after_frame", 32'(vif.o_thresh), 32'd100);
        pix_probe("bin_110", 8'd110, 8'hFF);
`endif
        chk("frame_cnt_1", 32'(vif.o_frame_cnt), 32'd1);
        pix_probe("bin_111", 8'd111, 8'hFF);

        vsync_pulse();
        idle(10);
        chk("frame_cnt_2", 32'(vif.o_frame_cnt), 32'd2);
        vsync_pulse();
        idle(10);
`ifdef YC_ADAPTIVE_THRESH_EN
        chk("thresh_empty_frame", 32'(vif.o_thresh), 32'd111);
`else
        chk("thresh_empty_frame", 32'(vif.o_thresh), 32'd100);
`endif
        chk("frame_cnt_empty", 32'(vif.o_frame_cnt), 32'd3);

        for (int f = 0; f < 4; f++) begin
            vsync_pulse();
            w = $urandom_range(4, 24);
            l = $urandom_range(2, 4);
            for (int j = 0; j < l; j++) line(w, 1'b1);
        end

        // Reset in the middle of an active line.
        vsync_pulse();
        step(1'b0, 1'b1, 1'b0, 24'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 24'($urandom));
        apply_reset();
        for (int i = 0; i < 8; i++) pix(8'd250);
        chk("post_reset_de", 32'(vif.o_de), 32'd0);
        idle(3);
        for (int f = 0; f < 3; f++) begin
            vsync_pulse();
            w = $urandom_range(4, 24);
            for (int j = 0; j < 3; j++) line(w, 1'b1);
        end

        apply_reset();
        line(640, 1'b0);
        line(640, 1'b0);
        idle(10);
        chk("line_err_equal", 32'(vif.o_line_err), 32'd0);
        line(639, 1'b0);
        idle(10);
        chk("line_err_short", 32'(vif.o_line_err), 32'd1);
        idle(30);
        chk("line_err_sticky", 32'(vif.o_line_err), 32'd1);
        apply_reset();
        idle(OL + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
